opcode_sequencer: RTL and testbench

//  Sequential, handshaked successor to the combinational opcode decoder. Accepts

---
 rtl/opcode_sequencer_if.sv | 30 +++
 rtl/opcode_sequencer.sv | 148 ++++++++++++++
 tb/tb_opcode_sequencer.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/opcode_sequencer_if.sv
// Command, register-bank and response channels of the opcode sequencer.
// The slave view belongs to the sequencer; the master view to the host and bank side.
interface opcode_sequencer_if #(
    parameter int ARCHITECTURE = 32,
    parameter int DATA_W       = 64
);
    logic [ARCHITECTURE-1:0] cmd_data;
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic                    reg_we;
    logic                    reg_re;
    logic [1:0]              reg_addr;
    logic [DATA_W-1:0]       reg_wdata;
    logic [DATA_W-1:0]       reg_rdata;
    logic                    reg_rvalid;
    logic [DATA_W-1:0]       rsp_data;
    logic [1:0]              rsp_status;
    logic                    rsp_valid;
    logic                    rsp_ready;

    modport slave (
        input  cmd_data, cmd_valid, reg_rdata, reg_rvalid, rsp_ready,
        output cmd_ready, reg_we, reg_re, reg_addr, reg_wdata, rsp_data, rsp_status, rsp_valid
    );

    modport master (
        output cmd_data, cmd_valid, reg_rdata, reg_rvalid, rsp_ready,
        input  cmd_ready, reg_we, reg_re, reg_addr, reg_wdata, rsp_data, rsp_status, rsp_valid
    );
endinterface

// File: rtl/opcode_sequencer.sv
// Handshaked opcode sequencer: accepts one- or two-beat register commands, drives
// single-cycle DEC/CTL/MIRQ bank strobes and returns one status/data response per command.
module opcode_sequencer #(
    parameter int ARCHITECTURE = 32,
    parameter int DATA_W       = 64,
    parameter int RD_TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              reset,
    opcode_sequencer_if.slave bus
);
    localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

    typedef enum logic [2:0] {st_idle, st_beat2, st_write, st_read, st_resp} state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  wait_cnt;
    logic [1:0]        rsp_status_p1, rsp_status_n;
    logic [DATA_W-1:0] rsp_data_p1, rsp_data_n;
    logic              rsp_load;
    logic [1:0]        addr_p0;
    logic [31:0]       hi_p0;
    logic [13:0]       lo_p0;
    logic [63:0]       beat_ext;
    logic [3:0]        opcode;
    logic              beat_fire;

    function automatic logic is_read(input logic [3:0] op);
        return (op == 4'd4) || (op == 4'd5) || (op == 4'd6);
    endfunction

    function automatic logic is_write(input logic [3:0] op);
        return (op == 4'd7) || (op == 4'd8) || (op == 4'd9);
    endfunction

    function automatic logic [1:0] op_addr(input logic [3:0] op);
        case (op)
            4'd5, 4'd8: op_addr = 2'd1;
            4'd6, 4'd9: op_addr = 2'd2;
            default:    op_addr = 2'd0;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] write_data(input logic [1:0] addr, input logic [31:0] hi,
                                                     input logic [13:0] lo);
        case (addr)
            2'd1:    write_data = DATA_W'({hi, lo});
            2'd2:    write_data = DATA_W'({hi, lo[11:0]});
            default: write_data = DATA_W'(hi);
        endcase
    endfunction

    assign beat_ext  = 64'(bus.cmd_data);
    assign opcode    = beat_ext[3:0];
    assign beat_fire = bus.cmd_valid && bus.cmd_ready;

    // Control: state, read wait counter and response status
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= st_idle;
            wait_cnt      <= '0;
            rsp_status_p1 <= 2'b00;
        end else begin
            state <= state_n;
            if (state != st_read) begin
                wait_cnt <= '0;
            end else if (!bus.reg_rvalid) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (rsp_load) begin
                rsp_status_p1 <= rsp_status_n;
            end
        end
    end

    // Stage p0: command fields latched at beat transfer; p1: response payload
    always_ff @(posedge clk) begin
        if (state == st_idle && beat_fire) begin
            addr_p0 <= op_addr(opcode);
            hi_p0   <= beat_ext[63:32];
            lo_p0   <= beat_ext[17:4];
        end
        if (state == st_beat2 && beat_fire) begin
            hi_p0 <= beat_ext[31:0];
        end
        if (rsp_load) begin
            rsp_data_p1 <= rsp_data_n;
        end
    end

    always_comb begin
        state_n      = state;
        rsp_load     = 1'b0;
        rsp_status_n = 2'b00;
        rsp_data_n   = '0;
        case (state)
            st_idle: begin
                if (beat_fire) begin
                    if (is_write(opcode)) begin
                        state_n = (ARCHITECTURE == 32) ? st_beat2 : st_write;
                    end else if (is_read(opcode)) begin
                        state_n = st_read;
                    end else begin
                        state_n      = st_resp;
                        rsp_load     = 1'b1;
                        rsp_status_n = 2'b01;
                    end
                end
            end
            st_beat2: begin
                if (beat_fire) begin
                    state_n = st_write;
                end
            end
            st_write: begin
                state_n  = st_resp;
                rsp_load = 1'b1;
            end
            st_read: begin
                if (bus.reg_rvalid) begin
                    state_n    = st_resp;
                    rsp_load   = 1'b1;
                    rsp_data_n = bus.reg_rdata;
                end else if (wait_cnt == CNT_W'(RD_TIMEOUT - 1)) begin
                    state_n      = st_resp;
                    rsp_load     = 1'b1;
                    rsp_status_n = 2'b10;
                end
            end
            st_resp: begin
                if (bus.rsp_ready) begin
                    state_n = st_idle;
                end
            end
            default: state_n = st_idle;
        endcase
    end

    // Outputs are gated by state so everything reads zero outside its owning state
    assign bus.cmd_ready  = !reset && ((state == st_idle) || (state == st_beat2));
    assign bus.reg_we     = (state == st_write);
    assign bus.reg_re     = (state == st_read) && (wait_cnt == '0);
    assign bus.reg_addr   = ((state == st_write) || (state == st_read)) ? addr_p0 : 2'd0;
    assign bus.reg_wdata  = (state == st_write) ? write_data(addr_p0, hi_p0, lo_p0) : '0;
    assign bus.rsp_valid  = (state == st_resp);
    assign bus.rsp_data   = (state == st_resp) ? rsp_data_p1 : '0;
    assign bus.rsp_status = (state == st_resp) ? rsp_status_p1 : 2'b00;
endmodule

// File: tb/tb_opcode_sequencer.sv
// Bench for opcode_sequencer: a 32-bit and a 64-bit instance share one clock and reset;
// commands go to one of them and results are compared against a behavioural command model.
`timescale 1ns/1ps
module tb_opcode_sequencer;
    localparam int DW   = 64;
    localparam int TO32 = 4;
    localparam int TO64 = 6;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    opcode_sequencer_if #(.ARCHITECTURE(32), .DATA_W(DW)) bus32 ();
    opcode_sequencer_if #(.ARCHITECTURE(64), .DATA_W(DW)) bus64 ();

    opcode_sequencer #(.ARCHITECTURE(32), .DATA_W(DW), .RD_TIMEOUT(TO32)) dut32 (
        .clk(clk), .reset(reset), .bus(bus32.slave));
    opcode_sequencer #(.ARCHITECTURE(64), .DATA_W(DW), .RD_TIMEOUT(TO64)) dut64 (
        .clk(clk), .reset(reset), .bus(bus64.slave));

    logic        sel32;
    logic [63:0] cmd_data, reg_rdata;
    logic        cmd_valid, reg_rvalid, rsp_ready;

    assign bus32.cmd_data   = cmd_data[31:0];
    assign bus32.cmd_valid  = cmd_valid & sel32;
    assign bus32.reg_rdata  = reg_rdata;
    assign bus32.reg_rvalid = reg_rvalid & sel32;
    assign bus32.rsp_ready  = rsp_ready & sel32;
    assign bus64.cmd_data   = cmd_data;
    assign bus64.cmd_valid  = cmd_valid & ~sel32;
    assign bus64.reg_rdata  = reg_rdata;
    assign bus64.reg_rvalid = reg_rvalid & ~sel32;
    assign bus64.rsp_ready  = rsp_ready & ~sel32;

    logic        o_ready, o_we, o_re, o_valid;
    logic [1:0]  o_addr, o_st;
    logic [63:0] o_wdata, o_rdata;
    assign o_ready = sel32 ? bus32.cmd_ready  : bus64.cmd_ready;
    assign o_we    = sel32 ? bus32.reg_we     : bus64.reg_we;
    assign o_re    = sel32 ? bus32.reg_re     : bus64.reg_re;
    assign o_addr  = sel32 ? bus32.reg_addr   : bus64.reg_addr;
    assign o_wdata = sel32 ? bus32.reg_wdata  : bus64.reg_wdata;
    assign o_valid = sel32 ? bus32.rsp_valid  : bus64.rsp_valid;
    assign o_st    = sel32 ? bus32.rsp_status : bus64.rsp_status;
    assign o_rdata = sel32 ? bus32.rsp_data   : bus64.rsp_data;

    int checks = 0;
    int errors = 0;

    // Observations gathered by do_cmd
    int          ob_we_n, ob_re_n, ob_both, ob_busy_rdy, ob_unstable, ob_drift;
    int          ob_t_first, ob_t_last, ob_we_cyc, ob_re_cyc, ob_rsp_cyc;
    logic [1:0]  ob_we_addr, ob_re_addr, ob_st;
    logic [63:0] ob_wdata, ob_rdata;
    bit          ob_done;

    // kind: 0 illegal, 1 read, 2 write
    function automatic void model_cmd(input logic [63:0] c, output int kind, output logic [1:0] addr,
                                      output logic [63:0] wd);
        int op;
        logic [63:0] hi, lo;
        op   = int'(c[3:0]);
        hi   = c >> 32;
        lo   = c >> 4;
        kind = 0;
        addr = 2'd0;
        wd   = 64'd0;
        if (op >= 4 && op <= 6) begin
            kind = 1;
            addr = 2'(op - 4);
        end else if (op >= 7 && op <= 9) begin
            kind = 2;
            addr = 2'(op - 7);
            case (op)
                7:       wd = hi;
                8:       wd = hi * 64'd16384 + lo % 64'd16384;
                default: wd = hi * 64'd4096 + lo % 64'd4096;
            endcase
        end
    endfunction

    // Expected response and cycles from the last accepted beat to the first rsp_valid cycle
    function automatic void model_rsp(input int kind, input int rv_dly, input int to, input logic [63:0] rd,
                                      output logic [1:0] st, output logic [63:0] d, output int lat);
        st = 2'b00; d = 64'd0; lat = 2;
        if (kind == 0) begin
            st = 2'b01; lat = 1;
        end else if (kind == 1) begin
            if (rv_dly >= 0 && rv_dly < to) begin
                d = rd; lat = rv_dly + 2;
            end else begin
                st = 2'b10; lat = to + 1;
            end
        end
    endfunction

    // Drives one command to completion (host + bank behaviour) and records what the DUT did.
    task automatic do_cmd(input bit a32, input logic [63:0] c, input int gap, input int rv_dly,
                          input logic [63:0] rd, input int rdy_dly, input bit noise);
        int kind, beats, sent, gapc;
        logic [1:0] ea;
        logic [63:0] ew;
        bit fire, hs, real_rv;
        model_cmd(c, kind, ea, ew);
        beats = (a32 && kind == 2) ? 2 : 1;
        sent = 0; gapc = 0; hs = 1'b0;
        ob_we_n = 0; ob_re_n = 0; ob_both = 0; ob_busy_rdy = 0; ob_unstable = 0; ob_drift = 0;
        ob_t_first = -1; ob_t_last = -1; ob_we_cyc = -1; ob_re_cyc = -1; ob_rsp_cyc = -1;
        ob_we_addr = 2'd0; ob_re_addr = 2'd0; ob_st = 2'd0; ob_wdata = 64'd0; ob_rdata = 64'd0;
        sel32 = a32;
        #1;
        for (int cyc = 0; cyc < 300 && !hs; cyc++) begin
            if (o_we) begin ob_we_n++; ob_we_addr = o_addr; ob_wdata = o_wdata; ob_we_cyc = cyc; end
            if (o_re) begin ob_re_n++; ob_re_addr = o_addr; ob_re_cyc = cyc; end
            if (o_we && o_re) ob_both++;
            if (o_valid) begin
                if (ob_rsp_cyc < 0) begin
                    ob_rsp_cyc = cyc; ob_rdata = o_rdata; ob_st = o_st;
                end else if (o_rdata !== ob_rdata || o_st !== ob_st) begin
                    ob_unstable++;
                end
            end
            if (ob_re_cyc >= 0 && ob_rsp_cyc < 0 && o_addr !== ob_re_addr) ob_drift++;
            if (sent == beats && o_ready) ob_busy_rdy++;
            if (sent < beats && !(sent == 1 && gapc < gap)) begin
                cmd_valid = 1'b1;
                cmd_data  = (sent == 0) ? (a32 ? {32'h0, c[31:0]} : c) : {32'h0, c[63:32]};
            end else begin
                cmd_valid = 1'b0;
                cmd_data  = {$urandom, $urandom};
            end
            if (sent == 1) gapc++;
            real_rv    = (ob_re_cyc >= 0 && rv_dly >= 0 && cyc == ob_re_cyc + rv_dly);
            reg_rvalid = real_rv || (noise && (kind != 1 || sent == 0) && $urandom_range(0, 1) == 1);
            reg_rdata  = real_rv ? rd : {$urandom, $urandom};
            rsp_ready  = (ob_rsp_cyc >= 0 && cyc >= ob_rsp_cyc + rdy_dly);
            fire = cmd_valid && o_ready;
            hs   = o_valid && rsp_ready;
            @(posedge clk);
            if (fire) begin
                if (sent == 0) ob_t_first = cyc;
                ob_t_last = cyc;
                sent++;
            end
            @(negedge clk);
        end
        ob_done    = hs;
        cmd_valid  = 1'b0;
        reg_rvalid = 1'b0;
        rsp_ready  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b0; reg_rvalid = 1'b0; rsp_ready = 1'b0;
        cmd_data = 64'd0; reg_rdata = 64'd0; sel32 = 1'b0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel32 = s[0];
            #1;
            checks++;
            if ({o_ready, o_we, o_re, o_addr, o_wdata, o_valid, o_st, o_rdata} !== '0) begin
                errors++;
                $display("FAIL reset_held sel32=%0d got ready=%b we=%b re=%b valid=%b wdata=%h required all zero",
                         s, o_ready, o_we, o_re, o_valid, o_wdata);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        for (int s = 0; s < 2; s++) begin
            sel32 = s[0];
            #1;
            checks++;
            if (o_ready !== 1'b1 || {o_we, o_re, o_addr, o_wdata, o_valid, o_st, o_rdata} !== '0) begin
                errors++;
                $display("FAIL reset_release sel32=%0d got ready=%b we=%b re=%b valid=%b required ready=1 rest 0",
                         s, o_ready, o_we, o_re, o_valid);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_write64();
        do_cmd(1'b0, 64'hDEADBEEF_00000007, 0, -1, 64'd0, 0, 1'b0);
        checks++;
        if (ob_we_n !== 1 || ob_re_n !== 0) begin
            errors++; $display("FAIL w64_strobes got we=%0d re=%0d required we=1 re=0", ob_we_n, ob_re_n);
        end
        checks++;
        if (ob_we_addr !== 2'd0 || ob_wdata !== 64'hDEADBEEF) begin
            errors++; $display("FAIL w64_data got addr=%0d wdata=%h required addr=0 wdata=deadbeef", ob_we_addr, ob_wdata);
        end
        checks++;
        if (ob_we_cyc !== ob_t_first + 1 || ob_rsp_cyc !== ob_t_first + 2) begin
            errors++; $display("FAIL w64_latency got we@%0d rsp@%0d beat@%0d required +1/+2", ob_we_cyc, ob_rsp_cyc, ob_t_first);
        end
        checks++;
        if (!ob_done || ob_st !== 2'b00 || ob_rdata !== 64'd0) begin
            errors++; $display("FAIL w64_rsp got done=%0d status=%b data=%h required 1/00/0", ob_done, ob_st, ob_rdata);
        end
    endtask

    task automatic test_write32();
        do_cmd(1'b1, {32'hCAFE_0001, 32'h0001_2348}, 2, -1, 64'd0, 1, 1'b1);
        checks++;
        if (ob_we_n !== 1 || ob_re_n !== 0 || ob_we_addr !== 2'd1) begin
            errors++; $display("FAIL w32_strobes got we=%0d re=%0d addr=%0d required 1/0/1", ob_we_n, ob_re_n, ob_we_addr);
        end
        checks++;
        if (ob_wdata !== 64'h0000_32BF_8000_5234) begin
            errors++; $display("FAIL w32_wdata got %h required 000032bf80005234", ob_wdata);
        end
        checks++;
        if (ob_t_last !== ob_t_first + 3 || ob_we_cyc !== ob_t_last + 1 || ob_rsp_cyc !== ob_t_last + 2) begin
            errors++; $display("FAIL w32_latency got beats@%0d,%0d we@%0d rsp@%0d", ob_t_first, ob_t_last, ob_we_cyc, ob_rsp_cyc);
        end
        checks++;
        if (!ob_done || ob_st !== 2'b00 || ob_rdata !== 64'd0 || ob_busy_rdy !== 0) begin
            errors++; $display("FAIL w32_rsp got done=%0d status=%b data=%h busy_ready=%0d", ob_done, ob_st, ob_rdata, ob_busy_rdy);
        end
    endtask

    task automatic test_read_stall();
        do_cmd(1'b0, 64'h0000_0000_0000_0006, 0, 3, 64'hABC, 5, 1'b0);
        checks++;
        if (ob_re_n !== 1 || ob_we_n !== 0 || ob_re_addr !== 2'd2 || ob_drift !== 0) begin
            errors++; $display("FAIL rd_strobes got re=%0d we=%0d addr=%0d drift=%0d required 1/0/2/0", ob_re_n, ob_we_n, ob_re_addr, ob_drift);
        end
        checks++;
        if (!ob_done || ob_rdata !== 64'hABC || ob_st !== 2'b00) begin
            errors++; $display("FAIL rd_rsp got done=%0d data=%h status=%b required 1/abc/00", ob_done, ob_rdata, ob_st);
        end
        checks++;
        if (ob_unstable !== 0 || ob_rsp_cyc !== ob_re_cyc + 4 || ob_re_cyc !== ob_t_first + 1) begin
            errors++; $display("FAIL rd_hold got unstable=%0d re@%0d rsp@%0d beat@%0d", ob_unstable, ob_re_cyc, ob_rsp_cyc, ob_t_first);
        end
    endtask

    task automatic test_timeout();
        do_cmd(1'b1, 64'h4, 0, -1, 64'd0, 0, 1'b0);
        checks++;
        if (!ob_done || ob_st !== 2'b10 || ob_rdata !== 64'd0 || ob_rsp_cyc - ob_re_cyc !== TO32) begin
            errors++; $display("FAIL timeout32 got status=%b data=%h cycles=%0d required 10/0/%0d", ob_st, ob_rdata, ob_rsp_cyc - ob_re_cyc, TO32);
        end
        checks++;
        if (ob_re_n !== 1 || ob_re_addr !== 2'd0 || ob_we_n !== 0) begin
            errors++; $display("FAIL timeout32_strobes got re=%0d addr=%0d we=%0d required 1/0/0", ob_re_n, ob_re_addr, ob_we_n);
        end
        do_cmd(1'b0, 64'h5, 0, -1, 64'd0, 2, 1'b0);
        checks++;
        if (!ob_done || ob_st !== 2'b10 || ob_rsp_cyc - ob_re_cyc !== TO64 || ob_unstable !== 0) begin
            errors++; $display("FAIL timeout64 got status=%b cycles=%0d required 10/%0d", ob_st, ob_rsp_cyc - ob_re_cyc, TO64);
        end
        do_cmd(1'b1, 64'h5, 0, TO32 - 1, 64'h1234_5678_9ABC_DEF0, 0, 1'b0);
        checks++;
        if (ob_st !== 2'b00 || ob_rdata !== 64'h1234_5678_9ABC_DEF0 || ob_re_addr !== 2'd1) begin
            errors++; $display("FAIL last_cycle_read got status=%b data=%h addr=%0d required 00/123456789abcdef0/1", ob_st, ob_rdata, ob_re_addr);
        end
    endtask

    task automatic test_illegal();
        logic [3:0] ops [4];
        ops[0] = 4'hF; ops[1] = 4'h0; ops[2] = 4'h3; ops[3] = 4'hA;
        for (int i = 0; i < 4; i++) begin
            do_cmd(i[0] == 1'b0, {$urandom, 28'h0ABCDE0, ops[i]}, 0, -1, 64'd0, 4, 1'b1);
            checks++;
            if (ob_we_n !== 0 || ob_re_n !== 0) begin
                errors++; $display("FAIL illegal_strobes op=%h got we=%0d re=%0d required 0/0", ops[i], ob_we_n, ob_re_n);
            end
            checks++;
            if (!ob_done || ob_st !== 2'b01 || ob_rdata !== 64'd0 || ob_rsp_cyc !== ob_t_first + 1) begin
                errors++; $display("FAIL illegal_rsp op=%h got status=%b data=%h rsp@%0d beat@%0d required 01/0/+1", ops[i], ob_st, ob_rdata, ob_rsp_cyc, ob_t_first);
            end
            checks++;
            if (ob_busy_rdy !== 0 || ob_unstable !== 0) begin
                errors++; $display("FAIL illegal_busy op=%h got busy_ready=%0d unstable=%0d required 0/0", ops[i], ob_busy_rdy, ob_unstable);
            end
        end
    endtask

    task automatic test_reset_beat2();
        int we_seen;
        we_seen = 0;
        sel32 = 1'b1;
        #1;
        cmd_data = {32'h0, 32'h1234_5677};
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        checks++;
        if (o_ready !== 1'b1 || o_we !== 1'b0) begin
            errors++; $display("FAIL beat2_wait got ready=%b we=%b required 1/0", o_ready, o_we);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({o_ready, o_we, o_re, o_addr, o_wdata, o_valid, o_st, o_rdata} !== '0) begin
            errors++; $display("FAIL beat2_reset got ready=%b we=%b re=%b valid=%b required all zero", o_ready, o_we, o_re, o_valid);
        end
        repeat (2) begin
            @(negedge clk);
            if (o_we) we_seen++;
        end
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (o_we || o_re || o_valid) we_seen++;
        end
        checks++;
        if (we_seen !== 0 || o_ready !== 1'b1) begin
            errors++; $display("FAIL beat2_dropped got strobes=%0d ready=%b required 0/1", we_seen, o_ready);
        end
        do_cmd(1'b1, {32'h0BAD_F00D, 32'h0000_0007}, 0, -1, 64'd0, 0, 1'b0);
        checks++;
        if (!ob_done || ob_we_n !== 1 || ob_we_addr !== 2'd0 || ob_wdata !== 64'h0BAD_F00D || ob_st !== 2'b00) begin
            errors++; $display("FAIL beat2_recover got we=%0d addr=%0d wdata=%h status=%b required 1/0/0badf00d/00", ob_we_n, ob_we_addr, ob_wdata, ob_st);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] cmds [5];
        bit          arch [5];
        int kind, lat;
        logic [1:0] ea, est;
        logic [63:0] ew, ed;
        cmds[0] = 64'h1111_2222_3333_4449; arch[0] = 1'b1;
        cmds[1] = 64'h0000_0000_0000_0005; arch[1] = 1'b1;
        cmds[2] = 64'h8765_4321_FFFF_FFF8; arch[2] = 1'b0;
        cmds[3] = 64'h0000_0000_0000_000B; arch[3] = 1'b0;
        cmds[4] = 64'h0000_0000_0000_0004; arch[4] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            model_cmd(cmds[i], kind, ea, ew);
            model_rsp(kind, 0, arch[i] ? TO32 : TO64, 64'h5A5A_0000_0000_00A5 + 64'(i), est, ed, lat);
            do_cmd(arch[i], cmds[i], 0, 0, 64'h5A5A_0000_0000_00A5 + 64'(i), 0, 1'b0);
            checks++;
            if (ob_t_first !== 0 || ob_rsp_cyc - ob_t_last !== lat) begin
                errors++; $display("FAIL b2b_timing cmd=%0d got first_beat@%0d latency=%0d required 0/%0d", i, ob_t_first, ob_rsp_cyc - ob_t_last, lat);
            end
            checks++;
            if (!ob_done || ob_st !== est || ob_rdata !== ed || (kind == 2 && ob_wdata !== ew)) begin
                errors++; $display("FAIL b2b_rsp cmd=%0d got status=%b data=%h wdata=%h required %b/%h/%h", i, ob_st, ob_rdata, ob_wdata, est, ed, ew);
            end
        end
    endtask

    task automatic test_random();
        int kind, lat, gap, rv_dly, rdy_dly, to;
        bit a32, noise;
        logic [1:0] ea, est;
        logic [63:0] c, ew, ed, rd;
        for (int i = 0; i < 60; i++) begin
            a32 = $urandom_range(0, 1) == 1;
            to  = a32 ? TO32 : TO64;
            c   = {$urandom, $urandom};
            c[3:0] = 4'($urandom_range(0, 15));
            rd      = {$urandom, $urandom};
            gap     = $urandom_range(0, 2);
            rv_dly  = $urandom_range(0, to + 1);
            rdy_dly = $urandom_range(0, 3);
            noise   = $urandom_range(0, 1) == 1;
            model_cmd(c, kind, ea, ew);
            model_rsp(kind, rv_dly, to, rd, est, ed, lat);
            do_cmd(a32, c, gap, rv_dly, rd, rdy_dly, noise);
            checks++;
            if ((kind == 2 && (ob_we_n !== 1 || ob_re_n !== 0 || ob_we_addr !== ea || ob_wdata !== ew)) ||
                (kind == 1 && (ob_re_n !== 1 || ob_we_n !== 0 || ob_re_addr !== ea)) ||
                (kind == 0 && (ob_we_n !== 0 || ob_re_n !== 0))) begin
                errors++; $display("FAIL rand_strobes i=%0d cmd=%h got we=%0d re=%0d waddr=%0d raddr=%0d wdata=%h required addr=%0d wdata=%h",
                                   i, c, ob_we_n, ob_re_n, ob_we_addr, ob_re_addr, ob_wdata, ea, ew);
            end
            checks++;
            if (!ob_done || ob_st !== est || ob_rdata !== ed) begin
                errors++; $display("FAIL rand_rsp i=%0d cmd=%h got done=%0d status=%b data=%h required %b/%h", i, c, ob_done, ob_st, ob_rdata, est, ed);
            end
            checks++;
            if (ob_rsp_cyc - ob_t_last !== lat) begin
                errors++; $display("FAIL rand_latency i=%0d cmd=%h got %0d required %0d", i, c, ob_rsp_cyc - ob_t_last, lat);
            end
            checks++;
            if (ob_both !== 0 || ob_busy_rdy !== 0 || ob_unstable !== 0 || ob_drift !== 0) begin
                errors++; $display("FAIL rand_protocol i=%0d got both=%0d busy_ready=%0d unstable=%0d drift=%0d required all 0",
                                   i, ob_both, ob_busy_rdy, ob_unstable, ob_drift);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write64();
        test_write32();
        test_read_stall();
        test_timeout();
        test_illegal();
        test_reset_beat2();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
